// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus wires shared by apb_master and its environment.
// The master modport is the apb_master view; slave is the view of whoever drives commands and models the slaves.
interface apb_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL1;
    logic       PSEL2;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// APB master, IDLE/SETUP/ACCESS, one command at a time; rsp_valid 3 cycles after accept with a zero-wait slave.
// cmd_ready only in IDLE, so commands stall while the slave holds PREADY low; APB_MASTER_TIMEOUT_EN adds an abort watchdog.
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    apb_master_if.master bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0] state;
    logic       psel1_q;
    logic       psel2_q;
    logic       penable_q;
    logic       pwrite_q;
    logic [7:0] paddr_q;
    logic [7:0] pwdata_q;
    logic       rsp_vld_q;
    logic [7:0] rsp_rdata_q;
    logic       limit_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       err_q;

    // Abort on the edge that ends the TIMEOUT_CYCLES-th stalled ACCESS cycle.
    assign limit_hit = (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wait_cnt <= 8'h00;
            err_q    <= 1'b0;
        end else if (state == SETUP) begin
            wait_cnt <= 8'h00;
        end else if (state == ACCESS) begin
            if (bus.PREADY || limit_hit) begin
                err_q <= !bus.PREADY;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign limit_hit   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= IDLE;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 8'h00;
            pwdata_q    <= 8'h00;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            rsp_vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state    <= SETUP;
                        pwrite_q <= bus.cmd_write;
                        paddr_q  <= bus.cmd_addr;
                        pwdata_q <= bus.cmd_wdata;
                        psel1_q  <= bus.cmd_addr[7];
                        psel2_q  <= !bus.cmd_addr[7];
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    // PREADY wins over the watchdog when both land on the same edge.
                    if (bus.PREADY || limit_hit) begin
                        state       <= IDLE;
                        psel1_q     <= 1'b0;
                        psel2_q     <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_vld_q   <= 1'b1;
                        rsp_rdata_q <= (bus.PREADY && !pwrite_q) ? bus.PRDATA : 8'h00;
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel1_q   <= 1'b0;
                    psel2_q   <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.PSEL1     = psel1_q;
    assign bus.PSEL2     = psel2_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule
